// File: rtl/unified_mem_responder.sv
// rtl/unified_mem_responder.sv - word-organised RAM responder with wait states for the unified memory port
//
// Accepts one request per handshake, waits WAIT_STATES cycles, commits the
// access and returns a one-cycle ready pulse with read data and an error flag.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   mem_req_i         request strobe, sampled in IDLE or DONE
//   mem_addr_i        byte address
//   mem_rw_mode_i     1 = read, 0 = write
//   mem_write_data_i  store data
//   mem_byte_en_i     store byte enables
//   mem_read_data_o   registered read data, valid with mem_ready_o
//   mem_ready_o       one-cycle response pulse
//   mem_busy_o        high while a request waits out its wait states
//   mem_err_o         high with mem_ready_o for misaligned / out-of-range accesses

module unified_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_rw_mode_i,
  input  logic [31:0] mem_write_data_i,
  input  logic [3:0]  mem_byte_en_i,
  output logic [31:0] mem_read_data_o,
  output logic        mem_ready_o,
  output logic        mem_busy_o,
  output logic        mem_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [2:0]  wait_cnt_q;
  logic [31:0] addr_q;
  logic        rw_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] read_data_q;
  logic        ready_q;
  logic        busy_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic [31:0]   cmt_addr;
  logic          cmt_rw;
  logic [31:0]   cmt_wdata;
  logic [3:0]    cmt_be;
  logic          cmt_err;
  logic [AW-1:0] cmt_idx;
  logic          cmt_write;

  assign accept = mem_req_i && (state_q == S_IDLE || state_q == S_DONE);

  // With no wait states the access commits on the accepting edge itself, so
  // the request registers are not yet loaded and the live inputs are used.
  assign commit    = (WAIT_STATES == 0) ? accept : (state_q == S_WAIT && wait_cnt_q == 3'd0);
  assign cmt_addr  = (WAIT_STATES == 0) ? mem_addr_i       : addr_q;
  assign cmt_rw    = (WAIT_STATES == 0) ? mem_rw_mode_i    : rw_q;
  assign cmt_wdata = (WAIT_STATES == 0) ? mem_write_data_i : wdata_q;
  assign cmt_be    = (WAIT_STATES == 0) ? mem_byte_en_i    : be_q;

  // Extra leading zero keeps the range check correct even for the largest depth.
  assign cmt_err   = (cmt_addr[1:0] != 2'b00) ||
                     ({1'b0, cmt_addr[31:2]} >= 31'(DEPTH_WORDS));
  assign cmt_idx   = cmt_addr[AW+1:2];

  // rst_ni gating stops a zero-wait-state accept path from writing during reset.
  assign cmt_write = commit && !cmt_err && !cmt_rw && rst_ni;

  // Storage array is deliberately not reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (cmt_write) begin
      for (int b = 0; b < 4; b++) begin
        if (cmt_be[b]) begin
          mem_q[cmt_idx][8*b +: 8] <= cmt_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 3'd0;
      addr_q      <= 32'd0;
      rw_q        <= 1'b0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      read_data_q <= 32'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ready_q <= commit;
      err_q   <= commit && cmt_err;

      if (commit) begin
        if (cmt_err) begin
          read_data_q <= 32'd0;
        end else if (cmt_rw) begin
          read_data_q <= mem_q[cmt_idx];
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            addr_q  <= mem_addr_i;
            rw_q    <= mem_rw_mode_i;
            wdata_q <= mem_write_data_i;
            be_q    <= mem_byte_en_i;
            if (WAIT_STATES == 0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= S_WAIT;
              wait_cnt_q <= WAIT_LOAD;
              busy_q     <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_data_o = read_data_q;
  assign mem_ready_o     = ready_q;
  assign mem_busy_o      = busy_q;
  assign mem_err_o       = err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// tb/tb_unified_mem_responder.sv - bench for unified_mem_responder at 0, 1 and 3 wait states
module tb_unified_mem_responder;

  localparam int DW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        rw = 1'b1;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'd0;

  logic [31:0] rd0, rd1, rd3;
  logic [2:0]  rdy, bsy, er;

  unified_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_addr_i(addr), .mem_rw_mode_i(rw),
    .mem_write_data_i(wdata), .mem_byte_en_i(be), .mem_read_data_o(rd0),
    .mem_ready_o(rdy[0]), .mem_busy_o(bsy[0]), .mem_err_o(er[0]));

  unified_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_addr_i(addr), .mem_rw_mode_i(rw),
    .mem_write_data_i(wdata), .mem_byte_en_i(be), .mem_read_data_o(rd1),
    .mem_ready_o(rdy[1]), .mem_busy_o(bsy[1]), .mem_err_o(er[1]));

  unified_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_addr_i(addr), .mem_rw_mode_i(rw),
    .mem_write_data_i(wdata), .mem_byte_en_i(be), .mem_read_data_o(rd3),
    .mem_ready_o(rdy[2]), .mem_busy_o(bsy[2]), .mem_err_o(er[2]));

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  function automatic logic [31:0] rdv(int i);
    return (i == 0) ? rd0 : (i == 1) ? rd1 : rd3;
  endfunction

  function automatic logic [31:0] pat(int k);
    return 32'h5A00_0000 + 32'(k) * 32'h0001_0203;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, edges remaining until the response,
  // a byte-level memory image with a known-byte mask, and expected outputs.
  int          ws  [3] = '{0, 1, 3};
  int          cnt [3] = '{0, 0, 0};
  bit          m_rdy [3];
  bit          m_err [3];
  logic [31:0] m_rd [3];
  logic [3:0]  m_rm [3];
  logic [31:0] la [3];
  logic        lrw [3];
  logic [31:0] lwd [3];
  logic [3:0]  lbe [3];
  logic [31:0] mm [3][DW];
  logic [3:0]  mk [3][DW];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_rdy[i] = 0; m_err[i] = 0; m_rd[i] = 32'd0; m_rm[i] = 4'hF;
      for (int w = 0; w < DW; w++) begin
        mm[i][w] = 32'd0;
        mk[i][w] = 4'h0;
      end
    end
  end

  task automatic model_commit(int i);
    bit e;
    int idx;
    e   = (la[i][1:0] != 2'b00) || (la[i][31:2] >= 30'(DW));
    idx = int'(la[i][31:2]) % DW;
    m_rdy[i] = 1;
    m_err[i] = e;
    if (e) begin
      m_rd[i] = 32'd0;
      m_rm[i] = 4'hF;
    end else if (lrw[i]) begin
      m_rd[i] = mm[i][idx];
      m_rm[i] = mk[i][idx];
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (lbe[i][b]) begin
          mm[i][idx][8*b +: 8] = lwd[i][8*b +: 8];
          mk[i][idx][b] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        cnt[i] = 0; m_rdy[i] = 0; m_err[i] = 0; m_rd[i] = 32'd0; m_rm[i] = 4'hF;
      end else begin
        m_rdy[i] = 0;
        m_err[i] = 0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) model_commit(i);
        end else if (req) begin
          la[i] = addr; lrw[i] = rw; lwd[i] = wdata; lbe[i] = be;
          if (ws[i] == 0) model_commit(i);
          else cnt[i] = ws[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [31:0] msk;
        for (int b = 0; b < 4; b++) msk[8*b +: 8] = m_rm[i][b] ? 8'hFF : 8'h00;
        chk($sformatf("model_ready[%0d]", ws[i]), 32'(rdy[i]), 32'(m_rdy[i]));
        chk($sformatf("model_err[%0d]", ws[i]), 32'(er[i]), 32'(m_err[i]));
        chk($sformatf("model_busy[%0d]", ws[i]), 32'(bsy[i]), 32'(cnt[i] > 0));
        chk($sformatf("model_rdata[%0d]", ws[i]), rdv(i) & msk, m_rd[i] & msk);
      end
    end
  end

  // One isolated request, with latency, busy length, err and data checked per instance.
  task automatic single(input string nm, input logic [31:0] a, input logic r,
                        input logic [31:0] wd, input logic [3:0] b, input logic exp_err,
                        input logic chk_d, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e3);
    int          lat [3];
    int          bc [3];
    logic [31:0] d [3];
    logic        ev [3];
    logic [31:0] ex [3];
    ex[0] = e0; ex[1] = e1; ex[2] = e3;
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; bc[i] = 0; d[i] = 32'd0; ev[i] = 1'b0;
    end
    @(posedge clk); #1;
    req = 1'b1; addr = a; rw = r; wdata = wd; be = b;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rdy[i] && lat[i] < 0) begin
          lat[i] = k; d[i] = rdv(i); ev[i] = er[i];
        end
        if (bsy[i]) bc[i]++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_latency[%0d]", nm, ws[i]), 32'(lat[i]), 32'(1 + ws[i]));
      chk($sformatf("%s_busy_cycles[%0d]", nm, ws[i]), 32'(bc[i]), 32'(ws[i]));
      chk($sformatf("%s_err[%0d]", nm, ws[i]), 32'(ev[i]), 32'(exp_err));
      if (chk_d) chk($sformatf("%s_rdata[%0d]", nm, ws[i]), d[i], ex[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt3;
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rdata[%0d]", ws[i]), rdv(i), 32'd0);
      chk($sformatf("reset_ready[%0d]", ws[i]), 32'(rdy[i]), 32'd0);
      chk($sformatf("reset_busy[%0d]", ws[i]), 32'(bsy[i]), 32'd0);
      chk($sformatf("reset_err[%0d]", ws[i]), 32'(er[i]), 32'd0);
    end

    for (int k = 0; k < 16; k++)
      single("prefill", 32'(k * 4), 1'b0, pat(k), 4'hF, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    single("wr_beef", 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    single("rd_beef", 32'h10, 1'b1, 32'd0, 4'h0, 1'b0, 1'b1,
           32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    single("wr_be5", 32'h10, 1'b0, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    single("rd_be5", 32'h10, 1'b1, 32'd0, 4'h0, 1'b0, 1'b1,
           32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44);
    single("wr_be0", 32'h10, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    single("rd_be0", 32'h10, 1'b1, 32'd0, 4'h0, 1'b0, 1'b1,
           32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44);
    single("rd_misal", 32'h12, 1'b1, 32'd0, 4'h0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    single("rd_refill", 32'h4, 1'b1, 32'd0, 4'h0, 1'b0, 1'b1, pat(1), pat(1), pat(1));
    single("wr_oob", 32'(4 * DW), 1'b0, 32'h0BAD_0BAD, 4'hF, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    single("rd_w0", 32'h0, 1'b1, 32'd0, 4'h0, 1'b0, 1'b1, 32'h5A00_0000, 32'h5A00_0000, 32'h5A00_0000);

    // Back-to-back reads on the zero-wait-state instance.
    @(posedge clk); #1;
    req = 1'b1; rw = 1'b1; addr = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) addr = 32'(4 * k);
      else req = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_ready_%0d", k), 32'(rdy[0]), 32'd1);
      chk($sformatf("b2b_busy_%0d", k), 32'(bsy[0]), 32'd0);
      chk($sformatf("b2b_rdata_%0d", k), rd0, pat(k - 1));
    end
    repeat (8) @(posedge clk);

    // Reset during the second wait cycle of the three-wait-state instance.
    @(posedge clk); #1;
    req = 1'b1; rw = 1'b0; addr = 32'h20; wdata = 32'hCAFE_F00D; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    cnt3 = 0;
    @(negedge clk);
    cnt3 += int'(rdy[2]);
    @(posedge clk);
    @(negedge clk);
    cnt3 += int'(rdy[2]);
    chk("rst_mid_busy_before", 32'(bsy[2]), 32'd1);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      cnt3 += int'(rdy[2]);
    end
    chk("rst_mid_no_ready", 32'(cnt3), 32'd0);
    single("rd_after_rst", 32'h20, 1'b1, 32'd0, 4'h0, 1'b0, 1'b1,
           32'hCAFE_F00D, 32'hCAFE_F00D, pat(8));

    // Random traffic, all three instances fed identical inputs.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      req   = ($urandom_range(0, 9) < 6);
      rw    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 11))
        0:       addr = $urandom;
        1:       addr = 32'(4 * DW - 4);
        2:       addr = 32'(4 * DW);
        3:       addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        4:       addr = 32'h8000_0000 | 32'($urandom_range(0, 3) * 4);
        default: addr = 32'($urandom_range(0, 15) * 4);
      endcase
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
